ldpc_cw_serializer: RTL and testbench
=====================================

LDPC_CW_SERIALIZER -- requirements
Module: ldpc_cw_serializer

Interface
REQ-001 SHALL have parameter OUT_W, default 9, output beat width in bits; legal values are divisors of 189 (1,3,7,9,21,27,63).
REQ-002 SHALL have parameter BEATS, default 189/OUT_W, beats per codeword; derived, not overridden.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port valid, input, 1, codeword present this cycle; no backpressure to encoder.
REQ-006 SHALL have port data_in, input, 27, systematic bits of codeword.
REQ-007 SHALL have port parity_in, input, 162, parity bits from qc_encoder data_out.
REQ-008 SHALL have port o_valid, output, 1, beat valid.
REQ-009 SHALL have port o_ready, input, 1, downstream accepts beat.
REQ-010 SHALL have port o_data, output, OUT_W, beat payload.
REQ-011 SHALL have port o_last, output, 1, final beat of codeword.
REQ-012 SHALL have port overflow, output, 1, sticky: a codeword was dropped.

Function
REQ-013 SHALL form codeword cw[188:0] = {data_in, parity_in}; beat k (0..BEATS-1) carries cw[188-k*OUT_W -: OUT_W], MSB first.
REQ-014 SHALL contain two 189-bit slots: HOLD (pending) and SHIFT (sending), each with a full flag.
REQ-015 SHALL have shifter FSM states IDLE (SHIFT empty) and SEND (SHIFT full); beat counter 0..BEATS-1.
REQ-016 Beat transfer SHALL occur iff o_valid && o_ready; o_data/o_valid SHALL hold stable while o_valid && !o_ready.
REQ-017 o_valid SHALL equal SHIFT full flag; o_last SHALL be 1 iff o_valid and counter == BEATS-1.
REQ-018 On transfer with counter < BEATS-1: counter increments, SHIFT shifts left by OUT_W.
REQ-019 On transfer with counter == BEATS-1: counter clears; if HOLD full (or valid arriving same cycle with HOLD empty) that codeword loads SHIFT next cycle without an idle beat; else FSM -> IDLE.
REQ-020 In IDLE, a valid codeword SHALL load SHIFT directly; o_valid asserted the following cycle (latency 1 cycle, first beat present at N+1).
REQ-021 In SEND, valid with HOLD empty SHALL write HOLD; HOLD drains into SHIFT per REQ-019.
REQ-022 valid with HOLD full and no same-cycle HOLD->SHIFT move SHALL drop the new codeword and set overflow; existing slots unaffected.
REQ-023 valid in the same cycle HOLD moves to SHIFT SHALL write HOLD (not dropped).
REQ-024 overflow SHALL remain 1 until rst.
REQ-025 Order of codewords out SHALL equal order of acceptance.

Reset
REQ-026 rst SHALL, next edge, clear both full flags, counter, FSM to IDLE, o_valid=0, o_last=0, o_data=0, overflow=0, regardless of a beat in flight.
REQ-027 valid during rst SHALL be ignored; first acceptance is the cycle after rst deasserts.
REQ-028 Slot data contents need not be reset; only flags/outputs listed above.

Configuration
REQ-029 Macro SER_DROP_CNT_EN SHALL, when defined, add output drop_cnt (8 bits) counting dropped codewords, saturating at 255, reset to 0.
REQ-030 Without SER_DROP_CNT_EN, drop_cnt port SHALL not exist; all other behaviour identical.

Verification
REQ-031 OUT_W=9, o_ready=1, one valid at cycle 0 with data_in=27'h4000001, parity_in=0 -> o_valid cycles 1..21, beat0=9'h100, beat2 bit0 path correct (beat2=9'h001... cw[170:162]), o_last only cycle 21.
REQ-032 o_ready=1, valid on cycles 0 and 5 -> 42 contiguous beats, no gap between beat 20 and 21, o_last at beats 20 and 41.
REQ-033 o_ready=0, valid cycles 0,2,4 -> codewords 0,1 held, codeword 2 dropped, overflow=1 from cycle 5; with SER_DROP_CNT_EN drop_cnt=1.
REQ-034 o_ready toggled pseudo-randomly, 50 codewords spaced 30 cycles -> scoreboard matches all, o_data stable during stalls, overflow=0.
REQ-035 rst asserted mid-codeword at beat 7 -> next cycle o_valid=0, overflow=0; new valid afterwards streams from beat 0.
REQ-036 valid in cycle of final beat transfer with HOLD empty -> that codeword's beat 0 presented next cycle, no drop.

Source files
------------

// File: rtl/ldpc_cw_serializer.sv
// Serializes a 189-bit LDPC codeword {data_in, parity_in} into OUT_W-bit beats, MSB first,
// using a one-deep HOLD slot and a SHIFT slot. Optional macro SER_DROP_CNT_EN adds drop_cnt.
//
// state  | meaning
// IDLE   | SHIFT slot empty, no beat offered
// SEND   | SHIFT slot full, beat r_cnt offered on o_data
module ldpc_cw_serializer #(
    parameter int OUT_W = 9,
    parameter int BEATS = 189 / OUT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [26:0]       data_in,
    input  logic [161:0]      parity_in,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [OUT_W-1:0]  o_data,
    output logic              o_last,
    output logic              overflow
`ifdef SER_DROP_CNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);

    localparam int CW_W  = 189;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CW_W-1:0]  r_shift;
    logic [CW_W-1:0]  r_hold;
    logic             r_hold_full;
    logic             r_overflow;

    logic [CW_W-1:0]  w_cw;
    logic             w_xfer;
    logic             w_final;
    logic             w_load_new;
    logic             w_load_hold;
    logic             w_hold_wr;
    logic             w_drop;

    assign w_cw   = {data_in, parity_in};
    assign w_xfer  = (r_state == S_SEND) && o_ready;
    assign w_final = w_xfer && (r_cnt == LAST_CNT);

    // An arriving codeword goes straight to SHIFT only when nothing is queued ahead of it.
    assign w_load_new  = valid && ((r_state == S_IDLE) || (w_final && !r_hold_full));
    assign w_load_hold = w_final && r_hold_full;
    assign w_hold_wr   = valid && (r_state == S_SEND) && (!r_hold_full || w_final) && !w_load_new;
    assign w_drop      = valid && (r_state == S_SEND) && r_hold_full && !w_final;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_hold_full <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_load_new || w_load_hold) begin
                r_state <= S_SEND;
                r_cnt   <= '0;
            end else if (w_final) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else if (w_xfer) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_hold_wr)
                r_hold_full <= 1'b1;
            else if (w_load_hold)
                r_hold_full <= 1'b0;

            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    // Slot payloads carry no reset; the flags above decide whether they mean anything.
    always_ff @(posedge clk) begin
        if (w_load_new)
            r_shift <= w_cw;
        else if (w_load_hold)
            r_shift <= r_hold;
        else if (w_xfer)
            r_shift <= {r_shift[CW_W-1-OUT_W:0], {OUT_W{1'b0}}};

        if (w_hold_wr)
            r_hold <= w_cw;
    end

`ifdef SER_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_drop_cnt <= '0;
        else if (w_drop && (r_drop_cnt != 8'hFF))
            r_drop_cnt <= r_drop_cnt + 8'd1;
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign o_valid  = (r_state == S_SEND);
    assign o_last   = o_valid && (r_cnt == LAST_CNT);
    assign o_data   = o_valid ? r_shift[CW_W-1 -: OUT_W] : '0;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_ldpc_cw_serializer.sv
// Directed self-checking bench for ldpc_cw_serializer at OUT_W=9 (21 beats per codeword).
module tb_ldpc_cw_serializer;

    localparam int OUT_W = 9;
    localparam int NB    = 21;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid;
    logic [26:0]      data_in;
    logic [161:0]     parity_in;
    logic             o_valid;
    logic             o_ready;
    logic [OUT_W-1:0] o_data;
    logic             o_last;
    logic             overflow;
`ifdef SER_DROP_CNT_EN
    logic [7:0]       drop_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [188:0] tb_cw  [0:3];
    int           tb_inj [0:3];

    ldpc_cw_serializer #(.OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .data_in   (data_in),
        .parity_in (parity_in),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_data    (o_data),
        .o_last    (o_last),
        .overflow  (overflow)
`ifdef SER_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [188:0] obs, input logic [188:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] beat_of(input logic [188:0] cw, input int k);
        logic [188:0] t;
        t = cw << (k * OUT_W);
        return t[188:180];
    endfunction

    task automatic drive(input logic [188:0] cw);
        valid     = 1'b1;
        data_in   = cw[188:162];
        parity_in = cw[161:0];
    endtask

    task automatic launch(input logic [188:0] cw);
        drive(cw);
        tick();
        valid = 1'b0;
    endtask

    // Walks n codewords from tb_cw[0..n-1]; tb_cw[0] is already presented.
    // tb_inj[i] is the beat index during which codeword i is offered on valid.
    task automatic check_beats(input int n, input bit stall);
        int  nxt;
        int  stalls;
        bit  rdy;
        nxt = 1;
        for (int b = 0; b < n * NB; b++) begin
            stalls = 0;
            do begin
                chk("o_valid", o_valid, 1'b1);
                chk("o_data", o_data, beat_of(tb_cw[b / NB], b % NB));
                chk("o_last", o_last, (b % NB) == NB - 1);
                if (nxt < n && tb_inj[nxt] == b && stalls == 0) begin
                    drive(tb_cw[nxt]);
                    nxt++;
                end else begin
                    valid = 1'b0;
                end
                rdy = (stall && stalls < 8) ? ($urandom_range(0, 1) == 1) : 1'b1;
                o_ready = rdy;
                stalls++;
                tick();
            end while (!rdy);
        end
        valid   = 1'b0;
        o_ready = 1'b1;
        chk("idle_after", o_valid, 1'b0);
    endtask

    initial begin
        logic [8:0] exp_b;
        rst = 1'b1; valid = 1'b0; o_ready = 1'b1;
        data_in = '0; parity_in = '0;
        for (int i = 0; i < 4; i++) tb_inj[i] = -1;

        // Reset, with valid asserted throughout (must be ignored)
        drive({27'h7FFFFFF, {162{1'b1}}});
        tick(); tick();
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_o_last", o_last, 1'b0);
        chk("rst_o_data", o_data, 9'h000);
        chk("rst_overflow", overflow, 1'b0);
`ifdef SER_DROP_CNT_EN
        chk("rst_drop_cnt", drop_cnt, 8'd0);
`endif
        rst = 1'b0; valid = 1'b0;
        tick();
        chk("rst_valid_ignored", o_valid, 1'b0);

        // Single codeword, hand-computed beats
        launch({27'h4000001, 162'h0});
        for (int k = 0; k < NB; k++) begin
            exp_b = (k == 0) ? 9'h100 : (k == 2) ? 9'h001 : 9'h000;
            chk("single_valid", o_valid, 1'b1);
            chk("single_data", o_data, exp_b);
            chk("single_last", o_last, k == NB - 1);
            tick();
        end
        chk("single_done", o_valid, 1'b0);

        // Two codewords, second queued in HOLD at beat 4 -> 42 contiguous beats
        tb_cw[0] = {27'h1234567, {6{27'h2ABCDEF}}};
        tb_cw[1] = {27'h7654321, {6{27'h5A5A5A5}}};
        tb_inj[1] = 4;
        launch(tb_cw[0]);
        check_beats(2, 1'b0);

        // Second codeword arrives exactly on the final-beat transfer with HOLD empty
        tb_cw[0] = {27'h0F0F0F0, {6{27'h3C3C3C3}}};
        tb_cw[1] = {27'h6DB6DB6, {6{27'h1111111}}};
        tb_inj[1] = 20;
        launch(tb_cw[0]);
        check_beats(2, 1'b0);

        // Third codeword arrives while HOLD moves into SHIFT: must be kept
        tb_cw[0] = {27'h0000001, {6{27'h4000000}}};
        tb_cw[1] = {27'h5555555, {6{27'h2222222}}};
        tb_cw[2] = {27'h3FFFFFF, {6{27'h0123456}}};
        tb_inj[1] = 4;
        tb_inj[2] = 20;
        launch(tb_cw[0]);
        check_beats(3, 1'b0);
        chk("no_overflow", overflow, 1'b0);

        // Stalled downstream: cycles 0,2,4 -> third codeword dropped
        for (int i = 0; i < 4; i++) tb_inj[i] = -1;
        tb_cw[0] = {27'h2468ACE, {6{27'h1357BDF}}};
        tb_cw[1] = {27'h7A7A7A7, {6{27'h0C0C0C0}}};
        o_ready = 1'b0;
        launch(tb_cw[0]);
        chk("stall_valid", o_valid, 1'b1);
        chk("stall_beat0", o_data, beat_of(tb_cw[0], 0));
        drive(tb_cw[1]);
        tick();
        valid = 1'b0;
        tick();
        chk("stall_no_ovf_yet", overflow, 1'b0);
        chk("stall_hold_data", o_data, beat_of(tb_cw[0], 0));
        drive({27'h6666666, {6{27'h7777777}}});
        tick();
        valid = 1'b0;
        chk("drop_overflow", overflow, 1'b1);
        chk("drop_data_kept", o_data, beat_of(tb_cw[0], 0));
        chk("drop_last", o_last, 1'b0);
`ifdef SER_DROP_CNT_EN
        chk("drop_cnt", drop_cnt, 8'd1);
`endif
        check_beats(2, 1'b1);
        chk("overflow_sticky", overflow, 1'b1);

        // Reset mid-codeword at beat 7
        o_ready = 1'b1;
        tb_cw[0] = {27'h1010101, {6{27'h6060606}}};
        launch(tb_cw[0]);
        for (int k = 0; k < 7; k++) tick();
        chk("pre_rst_beat7", o_data, beat_of(tb_cw[0], 7));
        rst = 1'b1;
        tick();
        chk("midrst_o_valid", o_valid, 1'b0);
        chk("midrst_o_last", o_last, 1'b0);
        chk("midrst_o_data", o_data, 9'h000);
        chk("midrst_overflow", overflow, 1'b0);
        rst = 1'b0;
        tick();
        tb_cw[0] = {27'h5F5F5F5, {6{27'h0A0A0A0}}};
        launch(tb_cw[0]);
        check_beats(1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
